// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard/forwarding controller.
// All hazard outputs are same-cycle combinational; state advances one step per clock.
package hazard_ctrl_pkg;

  typedef enum logic {
    RUN    = 1'b0,
    SQUASH = 1'b1
  } hz_state_t;

  // Single-bit fields per scoreboard entry: valid, we, load, use1, use2.
  localparam int HZ_ENT_FLAGS = 5;

  // Wide enough to hold FLUSH_CYCLES-1 for the largest legal FLUSH_CYCLES.
  localparam int HZ_FCNT_W = 3;

endpackage

// File: rtl/hz_scoreboard.sv
// Shift register of in-flight instructions (slot 0 = EX) with per-slot address matches.
// Advances every clock with no hold; a cycle without push shifts a bubble into slot 0.
module hz_scoreboard
  import hazard_ctrl_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DEPTH = 3,
  parameter bit ZERO_REG = 1'b1,
  localparam int ENT_W = HZ_ENT_FLAGS + 3 * ADDR_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              push,
  input  logic [ENT_W-1:0]  push_ent,
  input  logic [ADDR_W-1:0] q1_addr,
  input  logic [ADDR_W-1:0] q2_addr,
  output logic              head_valid,
  output logic              head_load,
  output logic              head_use1,
  output logic              head_use2,
  output logic              id_hit1,
  output logic              id_hit2,
  output logic [DEPTH-1:1]  fwd_hit1,
  output logic [DEPTH-1:1]  fwd_hit2
);

  typedef struct packed {
    logic              valid;
    logic              we;
    logic              load;
    logic [ADDR_W-1:0] wa;
    logic [ADDR_W-1:0] ra1;
    logic [ADDR_W-1:0] ra2;
    logic              use1;
    logic              use2;
  } sb_entry_t;

  sb_entry_t slot_q [DEPTH];
  sb_entry_t slot_d [DEPTH];

  function automatic logic hit(input sb_entry_t e, input logic [ADDR_W-1:0] r);
    return e.valid & e.we & (e.wa == r) & ~(ZERO_REG & (r == '0));
  endfunction

  always_comb begin
    slot_d[0] = push ? sb_entry_t'(push_ent) : '0;
    for (int i = 1; i < DEPTH; i++) begin
      slot_d[i] = slot_q[i-1];
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) slot_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) slot_q[i] <= slot_d[i];
    end
  end

  // Slot 0 is matched against the ID sources; older slots against slot 0's own sources.
  always_comb begin
    id_hit1  = hit(slot_q[0], q1_addr);
    id_hit2  = hit(slot_q[0], q2_addr);
    fwd_hit1 = '0;
    fwd_hit2 = '0;
    for (int i = 1; i < DEPTH; i++) begin
      fwd_hit1[i] = hit(slot_q[i], slot_q[0].ra1);
      fwd_hit2[i] = hit(slot_q[i], slot_q[0].ra2);
    end
  end

  assign head_valid = slot_q[0].valid;
  assign head_load  = slot_q[0].load;
  assign head_use1  = slot_q[0].use1;
  assign head_use2  = slot_q[0].use2;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller: EX forwarding selects, load-use stall, redirect squash FSM, event counters.
// Zero-latency combinational controls; stall holds the front end for one cycle per load-use.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DEPTH = 3,
  parameter int FLUSH_CYCLES = 1,
  parameter bit ZERO_REG = 1'b1,
  parameter int CNT_W = 16,
  localparam int SEL_W = $clog2(DEPTH)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              id_valid,
  input  logic [ADDR_W-1:0] id_ra1,
  input  logic [ADDR_W-1:0] id_ra2,
  input  logic              id_use1,
  input  logic              id_use2,
  input  logic [ADDR_W-1:0] id_wa,
  input  logic              id_we,
  input  logic              id_load,
  input  logic              ex_redirect,
  output logic              stall,
  output logic              flush_id,
  output logic              flush_ex,
  output logic [SEL_W-1:0]  fwd_sel_a,
  output logic [SEL_W-1:0]  fwd_sel_b,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam int ENT_W = HZ_ENT_FLAGS + 3 * ADDR_W;

  typedef struct packed {
    logic              valid;
    logic              we;
    logic              load;
    logic [ADDR_W-1:0] wa;
    logic [ADDR_W-1:0] ra1;
    logic [ADDR_W-1:0] ra2;
    logic              use1;
    logic              use2;
  } sb_entry_t;

  sb_entry_t            id_ent;
  logic                 push;
  logic                 head_valid, head_load, head_use1, head_use2;
  logic                 id_hit1, id_hit2;
  logic [DEPTH-1:1]     fwd_hit1, fwd_hit2;
  logic                 redirect_eff, load_use, flush;

  hz_state_t            state_q, state_d;
  logic [HZ_FCNT_W-1:0] fcnt_q, fcnt_d;
  logic [CNT_W-1:0]     stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]     flush_cnt_q, flush_cnt_d;

  always_comb begin
    id_ent       = '0;
    id_ent.valid = 1'b1;
    id_ent.we    = id_we;
    id_ent.load  = id_load;
    id_ent.wa    = id_wa;
    id_ent.ra1   = id_ra1;
    id_ent.ra2   = id_ra2;
    id_ent.use1  = id_use1;
    id_ent.use2  = id_use2;
  end

  assign push = id_valid & ~stall & ~flush_ex;

  hz_scoreboard #(
    .ADDR_W   (ADDR_W),
    .DEPTH    (DEPTH),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .CLK        (CLK),
    .RST        (RST),
    .push       (push),
    .push_ent   (ENT_W'(id_ent)),
    .q1_addr    (id_ra1),
    .q2_addr    (id_ra2),
    .head_valid (head_valid),
    .head_load  (head_load),
    .head_use1  (head_use1),
    .head_use2  (head_use2),
    .id_hit1    (id_hit1),
    .id_hit2    (id_hit2),
    .fwd_hit1   (fwd_hit1),
    .fwd_hit2   (fwd_hit2)
  );

  // Scanning oldest to youngest lets the youngest producer overwrite the select last.
  always_comb begin
    fwd_sel_a = '0;
    fwd_sel_b = '0;
    for (int k = DEPTH - 1; k >= 1; k--) begin
      if (head_valid & head_use1 & fwd_hit1[k]) fwd_sel_a = SEL_W'(k);
      if (head_valid & head_use2 & fwd_hit2[k]) fwd_sel_b = SEL_W'(k);
    end
  end

  assign redirect_eff = ex_redirect & head_valid & (state_q == RUN);
  assign load_use     = id_valid & head_valid & head_load &
                        ((id_use1 & id_hit1) | (id_use2 & id_hit2));
  assign flush        = redirect_eff | (state_q == SQUASH);
  assign stall        = load_use & ~flush;
  assign flush_id     = flush;
  assign flush_ex     = flush;
  assign stall_cnt    = stall_cnt_q;
  assign flush_cnt    = flush_cnt_q;

  always_comb begin
    state_d     = state_q;
    fcnt_d      = fcnt_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    case (state_q)
      RUN: begin
        if (redirect_eff && FLUSH_CYCLES > 1) begin
          state_d = SQUASH;
          fcnt_d  = HZ_FCNT_W'(FLUSH_CYCLES - 1);
        end
      end
      SQUASH: begin
        if (fcnt_q == HZ_FCNT_W'(1)) state_d = RUN;
        else                         fcnt_d  = fcnt_q - HZ_FCNT_W'(1);
      end
      default: state_d = RUN;
    endcase
    if (stall && stall_cnt_q != '1)        stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (redirect_eff && flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= RUN;
      fcnt_q      <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      fcnt_q      <= fcnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

endmodule
